// File: rtl/bview_streamer_if.sv
// Handshake bundle for bview_streamer: tensor input side, beat output side and status.
interface bview_streamer_if #(
  parameter int ISIZE_W    = 64,
  parameter int ISIZE_H    = 64,
  parameter int ISIZE_FEAT = 1
);
  localparam int NBEATS = ISIZE_FEAT * ISIZE_W;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic                                             clear_i;
  logic                                             in_valid_i;
  logic                                             in_ready_o;
  logic [ISIZE_FEAT-1:0][ISIZE_W-1:0][ISIZE_H-1:0]  layer_i;
  logic                                             out_valid_o;
  logic                                             out_ready_i;
  logic [ISIZE_H-1:0]                               out_data_o;
  logic [CW-1:0]                                    out_idx_o;
  logic                                             out_last_o;
  logic                                             busy_o;
  logic                                             done_o;

  modport master (
    output clear_i, in_valid_i, layer_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o, done_o
  );

  modport slave (
    input  clear_i, in_valid_i, layer_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o, done_o
  );
endinterface

// File: rtl/bview_streamer.sv
// Captures a binary 3D tensor and streams its flattened 1D view one row (beat) per handshake.
module bview_streamer #(
  parameter int ISIZE_W    = 64,
  parameter int ISIZE_H    = 64,
  parameter int ISIZE_FEAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  bview_streamer_if.slave bus
);
  localparam int NBEATS = ISIZE_FEAT * ISIZE_W;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBEATS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state;
  logic [CW-1:0]      idx;
  logic               in_ready;
  logic               out_valid;
  logic               out_last;
  logic               busy;
  logic               done;
  logic [ISIZE_H-1:0] beats_p0 [NBEATS];
  logic [ISIZE_H-1:0] data_p1;
  logic               take_in;
  logic               take_out;
  logic [CW-1:0]      idx_next;

  assign take_in  = (state == IDLE) && bus.in_valid_i && in_ready && !bus.clear_i;
  assign take_out = (state == STREAM) && out_valid && bus.out_ready_i && !bus.clear_i;
  assign idx_next = idx + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.clear_i) begin
        state     <= IDLE;
        idx       <= '0;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (take_in) begin
              state     <= STREAM;
              idx       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_last  <= (NBEATS == 1);
              busy      <= 1'b1;
            end
          end
          STREAM: begin
            if (take_out) begin
              if (idx == LAST_IDX) begin
                state     <= IDLE;
                idx       <= '0;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                idx      <= idx_next;
                out_last <= (idx_next == LAST_IDX);
              end
            end
          end
        endcase
      end
    end
  end

  // Stage p0: tensor stored in beat order (feature k reversed), p1: registered beat data
  always_ff @(posedge clk_i) begin
    if (take_in) begin
      for (int k = 0; k < ISIZE_FEAT; k++) begin
        for (int i = 0; i < ISIZE_W; i++) begin
          beats_p0[k*ISIZE_W + i] <= bus.layer_i[ISIZE_FEAT-1-k][i];
        end
      end
      data_p1 <= bus.layer_i[ISIZE_FEAT-1][0];
    end else if (take_out && (idx != LAST_IDX)) begin
      data_p1 <= beats_p0[idx_next];
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = data_p1;
  assign bus.out_idx_o   = idx;
  assign bus.out_last_o  = out_last;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
endmodule

// File: tb/tb_bview_streamer.sv
// Directed bench for bview_streamer with a 2x2x2 tensor (4 beats of 2 bits).
module tb_bview_streamer;
  localparam int W = 2;
  localparam int H = 2;
  localparam int F = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bview_streamer_if #(.ISIZE_W(W), .ISIZE_H(H), .ISIZE_FEAT(F)) bus ();

  bview_streamer #(.ISIZE_W(W), .ISIZE_H(H), .ISIZE_FEAT(F)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tensor A: f1 = {r1=11, r0=10}, f0 = {r1=01, r0=00}; tensor B: f1 = {00,01}, f0 = {10,11}
  localparam logic [7:0] TA = 8'b11_10_01_00;
  localparam logic [7:0] TB = 8'b00_01_10_11;
  logic [1:0] exp_a [4];
  logic [1:0] exp_b [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] t);
    bus.in_valid_i = 1'b1;
    bus.layer_i    = t;
    step();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.clear_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0; bus.layer_i = '0;
    #3;
    checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.done_o, bus.out_last_o, bus.out_idx_o} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", {bus.in_ready_o, bus.out_valid_o, bus.busy_o,
               bus.done_o, bus.out_last_o, bus.out_idx_o}, 7'b1000000);
    end
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.busy_o} !== 3'b100) begin
      failures++;
      $display("FAIL idle_after_reset got=%b want=100", {bus.in_ready_o, bus.out_valid_o, bus.busy_o});
    end
  endtask

  task automatic test_stream();
    bus.out_ready_i = 1'b1;
    accept(TA);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if ({bus.out_valid_o, bus.out_idx_o, bus.out_data_o, bus.out_last_o, bus.in_ready_o, bus.busy_o, bus.done_o}
          !== {1'b1, 2'(n), exp_a[n], (n == 3), 1'b0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL stream_beat%0d got v=%b idx=%0d d=%b last=%b rdy=%b busy=%b done=%b want d=%b",
                 n, bus.out_valid_o, bus.out_idx_o, bus.out_data_o, bus.out_last_o, bus.in_ready_o,
                 bus.busy_o, bus.done_o, exp_a[n]);
      end
      step();
    end
    checks++;
    if ({bus.done_o, bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.out_idx_o} !== 6'b110000) begin
      failures++;
      $display("FAIL stream_done got=%b want=110000",
               {bus.done_o, bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.out_idx_o});
    end
    step();
    checks++;
    if (bus.done_o !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle got=%b want=0", bus.done_o);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready_i = 1'b1;
    accept(TA);
    step();
    bus.out_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({bus.out_valid_o, bus.out_idx_o, bus.out_data_o, bus.out_last_o} !== {1'b1, 2'd1, 2'b11, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b idx=%0d d=%b want v=1 idx=1 d=11", c,
                 bus.out_valid_o, bus.out_idx_o, bus.out_data_o);
      end
      if (c < 3) step();
    end
    bus.out_ready_i = 1'b1;
    for (int n = 1; n < 4; n++) begin
      checks++;
      if ({bus.out_valid_o, bus.out_idx_o, bus.out_data_o, bus.out_last_o} !== {1'b1, 2'(n), exp_a[n], (n == 3)}) begin
        failures++;
        $display("FAIL bp_beat%0d got idx=%0d d=%b last=%b want d=%b", n, bus.out_idx_o,
                 bus.out_data_o, bus.out_last_o, exp_a[n]);
      end
      step();
    end
    checks++;
    if ({bus.done_o, bus.out_valid_o} !== 2'b10) begin
      failures++;
      $display("FAIL bp_done got=%b want=10", {bus.done_o, bus.out_valid_o});
    end
    step();
  endtask

  task automatic test_back_to_back();
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.layer_i     = TA;
    step();
    bus.layer_i = TB;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if ({bus.in_ready_o, bus.out_idx_o, bus.out_data_o} !== {1'b0, 2'(n), exp_a[n]}) begin
        failures++;
        $display("FAIL b2b_first%0d got rdy=%b idx=%0d d=%b want rdy=0 d=%b", n, bus.in_ready_o,
                 bus.out_idx_o, bus.out_data_o, exp_a[n]);
      end
      step();
    end
    checks++;
    if ({bus.done_o, bus.in_ready_o} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_done got=%b want=11", {bus.done_o, bus.in_ready_o});
    end
    step();
    bus.in_valid_i = 1'b0;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if ({bus.out_valid_o, bus.out_idx_o, bus.out_data_o, bus.out_last_o} !== {1'b1, 2'(n), exp_b[n], (n == 3)}) begin
        failures++;
        $display("FAIL b2b_second%0d got v=%b idx=%0d d=%b want d=%b", n, bus.out_valid_o,
                 bus.out_idx_o, bus.out_data_o, exp_b[n]);
      end
      step();
    end
    step();
  endtask

  task automatic test_clear();
    bus.out_ready_i = 1'b1;
    accept(TA);
    step(); step();
    checks++;
    if ({bus.out_idx_o, bus.out_data_o} !== {2'd2, 2'b00}) begin
      failures++;
      $display("FAIL clr_pre got idx=%0d d=%b want idx=2 d=00", bus.out_idx_o, bus.out_data_o);
    end
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    checks++;
    if ({bus.out_valid_o, bus.done_o, bus.out_idx_o, bus.in_ready_o, bus.busy_o} !== 6'b000010) begin
      failures++;
      $display("FAIL clr_idle got=%b want=000010",
               {bus.out_valid_o, bus.done_o, bus.out_idx_o, bus.in_ready_o, bus.busy_o});
    end
    step();
    checks++;
    if (bus.done_o !== 1'b0) begin
      failures++;
      $display("FAIL clr_nodone got=%b want=0", bus.done_o);
    end
    accept(TA);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if ({bus.out_valid_o, bus.out_idx_o, bus.out_data_o} !== {1'b1, 2'(n), exp_a[n]}) begin
        failures++;
        $display("FAIL clr_restart%0d got idx=%0d d=%b want d=%b", n, bus.out_idx_o, bus.out_data_o, exp_a[n]);
      end
      step();
    end
    step();
  endtask

  task automatic test_async_reset();
    bus.out_ready_i = 1'b1;
    accept(TA);
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.done_o, bus.out_last_o, bus.out_idx_o} !== 7'b1000000) begin
      failures++;
      $display("FAIL async_rst got=%b want=1000000", {bus.in_ready_o, bus.out_valid_o, bus.busy_o,
               bus.done_o, bus.out_last_o, bus.out_idx_o});
    end
    rst = 1'b0;
    accept(TA);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if ({bus.out_valid_o, bus.out_idx_o, bus.out_data_o, bus.out_last_o} !== {1'b1, 2'(n), exp_a[n], (n == 3)}) begin
        failures++;
        $display("FAIL rst_restart%0d got idx=%0d d=%b last=%b want d=%b", n, bus.out_idx_o,
                 bus.out_data_o, bus.out_last_o, exp_a[n]);
      end
      step();
    end
    checks++;
    if (bus.done_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_done got=%b want=1", bus.done_o);
    end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_a[0] = 2'b10; exp_a[1] = 2'b11; exp_a[2] = 2'b00; exp_a[3] = 2'b01;
    exp_b[0] = 2'b01; exp_b[1] = 2'b00; exp_b[2] = 2'b11; exp_b[3] = 2'b10;
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
